// File: rtl/pc_sequencer.sv
// pc_sequencer: multicycle fetch/execute control FSM driving the PC register.
// Sequence per instruction: FETCH (request at pc_cur until imem_ready),
// EXEC (wait for exec_done, latch next-PC target), UPDATE (one pc_write pulse).
// A level-sensitive halt parks the FSM in HALT whenever FETCH would be entered.
// Optional feature macro: PC_MISALIGN_TRAP_EN -- a misaligned jump/branch target
// redirects to TRAP_VECTOR with a trap pulse; when undefined, the target's low
// two bits are cleared instead and trap is tied low.
module pc_sequencer #(
   parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100,
   parameter int unsigned MAX_WAIT    = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        halt,
   input  logic [31:0] pc_cur,
   output logic        pc_write,
   output logic [31:0] pc_next,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   output logic        instr_valid,
   input  logic        exec_done,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   output logic        fetch_timeout,
   output logic        trap
);

   typedef enum logic [2:0] {RESET_S, FETCH, EXEC, UPDATE, HALT} state_t;

   state_t      state;
   logic [31:0] target_q;
   logic [31:0] wait_cnt;
   logic [31:0] raw_target;
   logic [31:0] sel_target;
   logic        redirect;
   logic        misaligned;

   // Next-PC selection: jump beats branch beats sequential PC+4 (wraps mod 2^32).
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      raw_target = pc_cur + 32'd4;
      redirect   = jump | branch_taken;
      if (jump)
         raw_target = jump_target;
      else if (branch_taken)
         raw_target = branch_target;
      misaligned = redirect && (raw_target[1:0] != 2'b00);
`ifdef PC_MISALIGN_TRAP_EN
      sel_target = misaligned ? TRAP_VECTOR : raw_target;
`else
      sel_target = redirect ? {raw_target[31:2], 2'b00} : raw_target;
`endif
   end

`ifndef PC_MISALIGN_TRAP_EN
   // Without the trap feature the vector and the misalignment flag have no consumer.
   logic unused_trap_inputs;
   assign unused_trap_inputs = ^{TRAP_VECTOR, misaligned};
`endif

   // Fetch address is only meaningful while a request is outstanding.
   assign imem_addr = imem_req ? pc_cur : 32'd0;
   // The target register is presented only during the UPDATE pulse.
   assign pc_next   = pc_write ? target_q : 32'd0;

`ifdef PC_MISALIGN_TRAP_EN
   logic trap_q;
   assign trap = trap_q;
`else
   assign trap = 1'b0;
`endif

   // Control FSM with registered outputs; reset clears state, outputs and the target.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= RESET_S;
         imem_req      <= 1'b0;
         instr_valid   <= 1'b0;
         pc_write      <= 1'b0;
         fetch_timeout <= 1'b0;
         target_q      <= 32'd0;
         wait_cnt      <= 32'd0;
`ifdef PC_MISALIGN_TRAP_EN
         trap_q        <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every register updates from pre-edge values.
         instr_valid <= 1'b0;
         pc_write    <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
         trap_q      <= 1'b0;
`endif
         case (state)
            // FETCH entry points (RESET_S, UPDATE, HALT) check halt so a parked
            // FSM never raises a request.
            RESET_S, UPDATE: begin
               state    <= halt ? HALT : FETCH;
               imem_req <= ~halt;
               wait_cnt <= 32'd0;
            end
            FETCH: begin
               if (imem_ready) begin
                  state       <= EXEC;
                  imem_req    <= 1'b0;
                  instr_valid <= 1'b1;
               end else if (MAX_WAIT != 0) begin
                  // The counter saturates at MAX_WAIT; one more wait is the overflow.
                  if (wait_cnt >= MAX_WAIT)
                     fetch_timeout <= 1'b1;
                  else
                     wait_cnt <= wait_cnt + 32'd1;
               end
            end
            EXEC: begin
               if (exec_done) begin
                  state    <= UPDATE;
                  target_q <= sel_target;
                  pc_write <= 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
                  trap_q   <= misaligned;
`endif
               end
            end
            HALT: begin
               if (!halt) begin
                  state    <= FETCH;
                  imem_req <= 1'b1;
                  wait_cnt <= 32'd0;
               end
            end
            default: begin
               state    <= RESET_S;
               imem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule
